// File: rtl/recovery_phase_sequencer_pkg.sv
// Shared types, widths and helpers for the commit-stage recovery sequencer.
package recovery_phase_sequencer_pkg;

    localparam int COMMIT_WIDTH   = 2;
    localparam int AL_ENTRY_NUM   = 64;
    localparam int REFETCH_TYPE_W = 3;
    localparam int EXEC_STATE_W   = 4;

    localparam int FLUSH_NUM_W = $clog2(COMMIT_WIDTH + 1);
    localparam int AL_PTR_W    = $clog2(AL_ENTRY_NUM);
    localparam int AL_CNT_W    = $clog2(AL_ENTRY_NUM + 1);

    typedef logic [AL_CNT_W-1:0]    FlushCountPath;
    typedef logic [AL_PTR_W-1:0]    FlushPtrPath;
    typedef logic [FLUSH_NUM_W-1:0] FlushNumPath;
    typedef logic [1:0]             PipelinePhase;

    typedef enum logic [1:0] {
        RSQ_COMMIT    = 2'd0,
        RSQ_RECOVER_0 = 2'd1,
        RSQ_RECOVER_1 = 2'd2
    } RecoverySeqState;

    // Pipeline phase encoding seen by the commit stage
    localparam PipelinePhase PHASE_COMMIT    = 2'd0;
    localparam PipelinePhase PHASE_RECOVER_0 = 2'd1;
    localparam PipelinePhase PHASE_RECOVER_1 = 2'd2;

    // Cause reported for backend-initiated recoveries
    localparam logic [EXEC_STATE_W-1:0] EXEC_STATE_SUCCESS = '0;

    // Entries the walk consumes in one cycle: min(COMMIT_WIDTH, remaining)
    function automatic FlushNumPath walk_step(input FlushCountPath remaining);
        if (remaining > FlushCountPath'(COMMIT_WIDTH)) begin
            walk_step = FlushNumPath'(COMMIT_WIDTH);
        end else begin
            walk_step = FlushNumPath'(remaining);
        end
    endfunction

    // Map sequencer state onto the externally visible pipeline phase
    function automatic PipelinePhase phase_of(input RecoverySeqState s);
        case (s)
            RSQ_COMMIT:    phase_of = PHASE_COMMIT;
            RSQ_RECOVER_0: phase_of = PHASE_RECOVER_0;
            RSQ_RECOVER_1: phase_of = PHASE_RECOVER_1;
            default:       phase_of = PHASE_COMMIT;
        endcase
    endfunction

endpackage

// File: rtl/recovery_phase_sequencer_walker.sv
// Flush walker: holds the walk pointer and remaining-entry counter and
// exposes the values the walk will present in the following cycle.
module recovery_flush_walker
    import recovery_phase_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  FlushPtrPath   start_ptr,
    input  FlushCountPath count,
    output FlushNumPath   n,
    output FlushPtrPath   ptr,
    output logic          last
);

    FlushPtrPath   walk_ptr_r;
    FlushPtrPath   walk_ptr_nxt_s;
    FlushCountPath remaining_r;
    FlushCountPath remaining_nxt_s;
    FlushNumPath   step_n_s;

    // Next counter values: load a new walk, retire one step, or hold
    always_comb begin
        step_n_s        = walk_step(remaining_r);
        walk_ptr_nxt_s  = walk_ptr_r;
        remaining_nxt_s = remaining_r;
        if (load) begin
            walk_ptr_nxt_s  = start_ptr;
            remaining_nxt_s = count;
        end else if (step) begin
            // Pointer wraps 0 -> AL-1 naturally in AL_PTR_W bits
            walk_ptr_nxt_s  = walk_ptr_r - FlushPtrPath'(step_n_s);
            remaining_nxt_s = remaining_r - FlushCountPath'(step_n_s);
        end else begin
            walk_ptr_nxt_s  = walk_ptr_r;
            remaining_nxt_s = remaining_r;
        end
    end

    // Walk counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            walk_ptr_r  <= '0;
            remaining_r <= '0;
        end else begin
            walk_ptr_r  <= walk_ptr_nxt_s;
            remaining_r <= remaining_nxt_s;
        end
    end

    assign n    = walk_step(remaining_nxt_s);
    assign ptr  = walk_ptr_nxt_s;
    assign last = (remaining_nxt_s == '0);

endmodule

// File: rtl/recovery_phase_sequencer.sv
// Responder side of the commit-stage recovery handshake: arbitrates commit
// and backend recovery requests, drives the pipeline phase and sequences
// the active-list flush walk for RMT restore.
module recovery_phase_sequencer
    import recovery_phase_sequencer_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmExceptionValid,
    input  logic [REFETCH_TYPE_W-1:0] cmRefetchType,
    input  logic [EXEC_STATE_W-1:0]   cmRecoveryCause,
    input  logic [FLUSH_NUM_W-1:0]    cmCommitNum,
    input  logic                      beExceptionValid,
    input  logic [REFETCH_TYPE_W-1:0] beRefetchType,
    input  logic [AL_PTR_W-1:0]       beAlPtr,
    input  logic [AL_PTR_W-1:0]       alHeadPtr,
    input  logic [AL_PTR_W-1:0]       alTailPtr,
    input  logic [AL_CNT_W-1:0]       alValidNum,
    input  logic                      storeDrainBusy,
    output logic [1:0]                phase,
    output logic                      unableToStartRecovery,
    output logic                      recoveryFromCommit,
    output logic [REFETCH_TYPE_W-1:0] recoveryRefetchType,
    output logic [EXEC_STATE_W-1:0]   recoveryCause,
    output logic                      flushAll,
    output logic                      recoverRMT,
    output logic [FLUSH_NUM_W-1:0]    flushNum,
    output logic [AL_PTR_W-1:0]       flushTailPtr,
    output logic                      recoveryDone
);

    RecoverySeqState state_r;
    RecoverySeqState state_nxt_s;
    logic            cm_accept_s;
    logic            be_accept_s;
    logic            walk_load_s;
    logic            walk_step_s;
    FlushPtrPath     walk_start_s;
    FlushCountPath   walk_count_s;
    FlushNumPath     walk_n_s;
    FlushPtrPath     walk_ptr_s;
    logic            walk_last_s;
    logic            unused_head_s;

    // The head pointer only marks the surviving boundary; the walk itself
    // is count-driven from the tail, so it ends there on its own.
    assign unused_head_s = ^alHeadPtr;

    assign unableToStartRecovery = (phase != PHASE_COMMIT) | storeDrainBusy;

    // Request arbitration (commit is older and wins) and walker control
    always_comb begin
        cm_accept_s  = 1'b0;
        be_accept_s  = 1'b0;
        walk_load_s  = 1'b0;
        walk_step_s  = 1'b0;
        walk_start_s = alTailPtr - FlushPtrPath'(1'b1);
        walk_count_s = '0;
        if ((state_r == RSQ_COMMIT) && !storeDrainBusy) begin
            if (cmExceptionValid) begin
                cm_accept_s  = 1'b1;
                walk_load_s  = 1'b1;
                walk_count_s = alValidNum - FlushCountPath'(cmCommitNum);
            end else if (beExceptionValid) begin
                // The mispredicted op survives, so the walk stops one short of it
                be_accept_s  = 1'b1;
                walk_load_s  = 1'b1;
                walk_count_s = FlushCountPath'(FlushPtrPath'(alTailPtr - beAlPtr - FlushPtrPath'(1'b1)));
            end else begin
                cm_accept_s  = 1'b0;
                be_accept_s  = 1'b0;
            end
        end else begin
            walk_step_s = (state_r == RSQ_RECOVER_1);
        end
    end

    // Next-state: RECOVER_0 lasts one cycle, RECOVER_1 runs until the walk drains
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RSQ_COMMIT: begin
                if (cm_accept_s || be_accept_s) begin
                    state_nxt_s = RSQ_RECOVER_0;
                end else begin
                    state_nxt_s = RSQ_COMMIT;
                end
            end
            RSQ_RECOVER_0, RSQ_RECOVER_1: begin
                if (walk_last_s) begin
                    state_nxt_s = RSQ_COMMIT;
                end else begin
                    state_nxt_s = RSQ_RECOVER_1;
                end
            end
            default: state_nxt_s = RSQ_COMMIT;
        endcase
    end

    // State register and registered phase/flush outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= RSQ_COMMIT;
            phase        <= PHASE_COMMIT;
            flushAll     <= 1'b0;
            recoverRMT   <= 1'b0;
            flushNum     <= '0;
            flushTailPtr <= '0;
            recoveryDone <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            phase        <= phase_of(state_nxt_s);
            flushAll     <= (state_nxt_s == RSQ_RECOVER_0);
            recoverRMT   <= (state_nxt_s == RSQ_RECOVER_1);
            flushNum     <= (state_nxt_s == RSQ_RECOVER_1) ? walk_n_s : '0;
            flushTailPtr <= (state_nxt_s == RSQ_RECOVER_1) ? walk_ptr_s : '0;
            recoveryDone <= (state_nxt_s == RSQ_COMMIT) && (state_r != RSQ_COMMIT);
        end
    end

    // Latch source, refetch type and cause of the accepted recovery
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            recoveryFromCommit  <= 1'b0;
            recoveryRefetchType <= '0;
            recoveryCause       <= '0;
        end else if (cm_accept_s) begin
            recoveryFromCommit  <= 1'b1;
            recoveryRefetchType <= cmRefetchType;
            recoveryCause       <= cmRecoveryCause;
        end else if (be_accept_s) begin
            recoveryFromCommit  <= 1'b0;
            recoveryRefetchType <= beRefetchType;
            recoveryCause       <= EXEC_STATE_SUCCESS;
        end else begin
            recoveryFromCommit  <= recoveryFromCommit;
            recoveryRefetchType <= recoveryRefetchType;
            recoveryCause       <= recoveryCause;
        end
    end

    recovery_flush_walker u_walker (
        .clk       (clk),
        .rst       (rst),
        .load      (walk_load_s),
        .step      (walk_step_s),
        .start_ptr (walk_start_s),
        .count     (walk_count_s),
        .n         (walk_n_s),
        .ptr       (walk_ptr_s),
        .last      (walk_last_s)
    );

endmodule

// File: tb/tb_recovery_phase_sequencer.sv
// Self-checking bench for recovery_phase_sequencer: directed scenarios plus
// randomized requests against a list-based model of the expected trace.
module tb_recovery_phase_sequencer;

    logic       clk;
    logic       rst;
    logic       cmExceptionValid;
    logic [2:0] cmRefetchType;
    logic [3:0] cmRecoveryCause;
    logic [1:0] cmCommitNum;
    logic       beExceptionValid;
    logic [2:0] beRefetchType;
    logic [5:0] beAlPtr;
    logic [5:0] alHeadPtr;
    logic [5:0] alTailPtr;
    logic [6:0] alValidNum;
    logic       storeDrainBusy;
    logic [1:0] phase;
    logic       unableToStartRecovery;
    logic       recoveryFromCommit;
    logic [2:0] recoveryRefetchType;
    logic [3:0] recoveryCause;
    logic       flushAll;
    logic       recoverRMT;
    logic [1:0] flushNum;
    logic [5:0] flushTailPtr;
    logic       recoveryDone;

    int n_checks;
    int n_fail;
    logic [21:0] exp_q[$];

    recovery_phase_sequencer dut (
        .clk                   (clk),
        .rst                   (rst),
        .cmExceptionValid      (cmExceptionValid),
        .cmRefetchType         (cmRefetchType),
        .cmRecoveryCause       (cmRecoveryCause),
        .cmCommitNum           (cmCommitNum),
        .beExceptionValid      (beExceptionValid),
        .beRefetchType         (beRefetchType),
        .beAlPtr               (beAlPtr),
        .alHeadPtr             (alHeadPtr),
        .alTailPtr             (alTailPtr),
        .alValidNum            (alValidNum),
        .storeDrainBusy        (storeDrainBusy),
        .phase                 (phase),
        .unableToStartRecovery (unableToStartRecovery),
        .recoveryFromCommit    (recoveryFromCommit),
        .recoveryRefetchType   (recoveryRefetchType),
        .recoveryCause         (recoveryCause),
        .flushAll              (flushAll),
        .recoverRMT            (recoverRMT),
        .flushNum              (flushNum),
        .flushTailPtr          (flushTailPtr),
        .recoveryDone          (recoveryDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {phase, flushAll, rmt, num, tailptr(if rmt), done, unable, from, type, cause}
    function automatic logic [21:0] obs_vec();
        return {phase, flushAll, recoverRMT, flushNum, flushTailPtr & {6{recoverRMT}},
                recoveryDone, unableToStartRecovery, recoveryFromCommit, recoveryRefetchType, recoveryCause};
    endfunction

    task automatic set_list(input int head, input int valid);
        alHeadPtr  = 6'(head);
        alValidNum = 7'(valid);
        alTailPtr  = 6'((head + valid) % 64);
    endtask

    task automatic drive_idle();
        cmExceptionValid = 1'b0;
        beExceptionValid = 1'b0;
        storeDrainBusy   = 1'b0;
    endtask

    // Requests during recovery must be ignored; randomize them while active
    task automatic drive_noise(input bit active);
        if (active) begin
            cmExceptionValid = 1'($urandom);
            beExceptionValid = 1'($urandom);
            cmRefetchType    = 3'($urandom);
            cmRecoveryCause  = 4'($urandom);
            cmCommitNum      = 2'($urandom_range(0, 2));
            beRefetchType    = 3'($urandom);
            beAlPtr          = 6'($urandom);
            alHeadPtr        = 6'($urandom);
            alTailPtr        = 6'($urandom);
            alValidNum       = 7'($urandom_range(0, 64));
        end else begin
            drive_idle();
        end
    endtask

    // Expected per-cycle trace after acceptance: RECOVER_0, walk steps, return
    task automatic model_trace(input int cnt, input int start, input logic [7:0] lat);
        int rem;
        int ptr;
        int n;
        exp_q.delete();
        exp_q.push_back({2'd1, 1'b1, 1'b0, 2'd0, 6'd0, 1'b0, 1'b1, lat});
        rem = cnt;
        ptr = start;
        while (rem > 0) begin
            n = (rem >= 2) ? 2 : rem;
            exp_q.push_back({2'd2, 1'b0, 1'b1, 2'(n), 6'(ptr), 1'b0, 1'b1, lat});
            ptr = (ptr - n + 64) % 64;
            rem = rem - n;
        end
        exp_q.push_back({2'd0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b1, 1'b0, lat});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        set_list(0, 0);
        cmRefetchType = 3'd0; cmRecoveryCause = 4'd0; cmCommitNum = 2'd0;
        beRefetchType = 3'd0; beAlPtr = 6'd0;
        #3;
        n_checks++;
        if (obs_vec() !== 22'd0) begin
            n_fail++; $display("FAIL reset_async: got %h expected %h", obs_vec(), 22'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs_vec() !== 22'd0) begin
            n_fail++; $display("FAIL reset_held: got %h expected %h", obs_vec(), 22'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs_vec() !== 22'd0) begin
            n_fail++; $display("FAIL reset_idle: got %h expected %h", obs_vec(), 22'd0);
        end
    endtask

    task automatic test_commit_walk();
        set_list(10, 5);
        cmCommitNum = 2'd1; cmRefetchType = 3'd5; cmRecoveryCause = 4'd9;
        cmExceptionValid = 1'b1;
        model_trace(4, 14, {1'b1, 3'd5, 4'd9});
        foreach (exp_q[i]) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs_vec() !== exp_q[i]) begin
                n_fail++; $display("FAIL commit_walk cycle %0d: got %h expected %h", i, obs_vec(), exp_q[i]);
            end
            drive_noise(i + 1 < exp_q.size());
        end
    endtask

    task automatic test_backend_wrap();
        set_list(57, 10);
        beAlPtr = 6'd62; beRefetchType = 3'd4; beExceptionValid = 1'b1;
        cmRefetchType = 3'd7; cmRecoveryCause = 4'd7;
        model_trace(4, 2, {1'b0, 3'd4, 4'd0});
        foreach (exp_q[i]) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs_vec() !== exp_q[i]) begin
                n_fail++; $display("FAIL backend_wrap cycle %0d: got %h expected %h", i, obs_vec(), exp_q[i]);
            end
            drive_noise(i + 1 < exp_q.size());
        end
    endtask

    task automatic test_simultaneous();
        set_list(20, 7);
        cmCommitNum = 2'd2; cmRefetchType = 3'd6; cmRecoveryCause = 4'd3;
        beAlPtr = 6'd22; beRefetchType = 3'd2;
        cmExceptionValid = 1'b1; beExceptionValid = 1'b1;
        model_trace(5, 26, {1'b1, 3'd6, 4'd3});
        foreach (exp_q[i]) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs_vec() !== exp_q[i]) begin
                n_fail++; $display("FAIL simultaneous cycle %0d: got %h expected %h", i, obs_vec(), exp_q[i]);
            end
            drive_noise(i + 1 < exp_q.size());
        end
    endtask

    task automatic test_drain_busy();
        set_list(0, 6);
        cmCommitNum = 2'd0; cmRefetchType = 3'd2; cmRecoveryCause = 4'd5;
        cmExceptionValid = 1'b1; storeDrainBusy = 1'b1;
        #1;
        n_checks++;
        if (unableToStartRecovery !== 1'b1) begin
            n_fail++; $display("FAIL drain_busy_comb: got %b expected 1", unableToStartRecovery);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({phase, flushAll, unableToStartRecovery} !== {2'd0, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL drain_busy_hold cycle %0d: got %b expected %b", c,
                                   {phase, flushAll, unableToStartRecovery}, {2'd0, 1'b0, 1'b1});
            end
        end
        storeDrainBusy = 1'b0;
        model_trace(6, 5, {1'b1, 3'd2, 4'd5});
        foreach (exp_q[i]) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs_vec() !== exp_q[i]) begin
                n_fail++; $display("FAIL drain_release cycle %0d: got %h expected %h", i, obs_vec(), exp_q[i]);
            end
            drive_noise(i + 1 < exp_q.size());
        end
    endtask

    task automatic test_zero_walk();
        set_list(40, 2);
        cmCommitNum = 2'd2; cmRefetchType = 3'd1; cmRecoveryCause = 4'd2;
        cmExceptionValid = 1'b1;
        model_trace(0, 41, {1'b1, 3'd1, 4'd2});
        foreach (exp_q[i]) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs_vec() !== exp_q[i]) begin
                n_fail++; $display("FAIL zero_walk cycle %0d: got %h expected %h", i, obs_vec(), exp_q[i]);
            end
            drive_noise(i + 1 < exp_q.size());
        end
    endtask

    task automatic test_full_list();
        set_list(33, 64);
        cmCommitNum = 2'd0; cmRefetchType = 3'd7; cmRecoveryCause = 4'd15;
        cmExceptionValid = 1'b1;
        model_trace(64, 32, {1'b1, 3'd7, 4'd15});
        foreach (exp_q[i]) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs_vec() !== exp_q[i]) begin
                n_fail++; $display("FAIL full_list cycle %0d: got %h expected %h", i, obs_vec(), exp_q[i]);
            end
            drive_noise(i + 1 < exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        set_list(0, 63);
        cmCommitNum = 2'd1; cmRefetchType = 3'd3; cmRecoveryCause = 4'd6;
        cmExceptionValid = 1'b1;
        @(posedge clk); #1;
        drive_idle();
        repeat (17) @(posedge clk);
        #1;
        n_checks++;
        if ({phase, flushNum, flushTailPtr} !== {2'd2, 2'd2, 6'd30}) begin
            n_fail++; $display("FAIL reset_mid_walk: got %b expected %b",
                               {phase, flushNum, flushTailPtr}, {2'd2, 2'd2, 6'd30});
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs_vec() !== 22'd0) begin
            n_fail++; $display("FAIL reset_mid_abort: got %h expected %h", obs_vec(), 22'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        set_list(5, 3);
        cmCommitNum = 2'd0; cmRefetchType = 3'd3; cmRecoveryCause = 4'd1;
        cmExceptionValid = 1'b1;
        model_trace(3, 7, {1'b1, 3'd3, 4'd1});
        foreach (exp_q[i]) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs_vec() !== exp_q[i]) begin
                n_fail++; $display("FAIL reset_mid_restart cycle %0d: got %h expected %h", i, obs_vec(), exp_q[i]);
            end
            drive_noise(i + 1 < exp_q.size());
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int head;
            int valid;
            int cn;
            int be;
            int kind;
            int cnt;
            int start;
            logic [2:0] ct;
            logic [2:0] bt;
            logic [3:0] cc;
            logic [7:0] lat;
            kind  = int'($urandom_range(0, 2));
            head  = int'($urandom_range(0, 63));
            valid = int'($urandom_range(0, 64));
            cn    = int'($urandom_range(0, (valid < 2) ? valid : 2));
            be    = int'($urandom_range(0, 63));
            ct    = 3'($urandom);
            bt    = 3'($urandom);
            cc    = 4'($urandom);
            set_list(head, valid);
            cmCommitNum = 2'(cn); cmRefetchType = ct; cmRecoveryCause = cc;
            beAlPtr = 6'(be); beRefetchType = bt;
            cmExceptionValid = (kind != 1);
            beExceptionValid = (kind != 0);
            if (kind != 1) begin
                cnt = valid - cn;
                lat = {1'b1, ct, cc};
            end else begin
                cnt = ((head + valid - be - 1) % 64 + 64) % 64;
                lat = {1'b0, bt, 4'd0};
            end
            start = (head + valid - 1 + 64) % 64;
            model_trace(cnt, start, lat);
            foreach (exp_q[i]) begin
                @(posedge clk); #1;
                n_checks++;
                if (obs_vec() !== exp_q[i]) begin
                    n_fail++; $display("FAIL random txn %0d cycle %0d: got %h expected %h", t, i, obs_vec(), exp_q[i]);
                end
                drive_noise(i + 1 < exp_q.size());
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_commit_walk();
        test_backend_wrap();
        test_simultaneous();
        test_drain_busy();
        test_zero_walk();
        test_full_list();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
